// File: rtl/fpu_result_stage.sv
//------------------------------------------------------------------------------
// fpu_result_stage : registered writeback stage for the add/sub unit, with a
// 2-entry skid buffer, IEEE-754 class tagging, sticky flags and retire counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fpu_result_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_result,
   input  logic             in_invalid,
   input  logic             in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_result,
   output logic             out_invalid,
   output logic             out_op,
   output logic [4:0]       out_class,
   output logic [3:0]       sticky_flags,
   output logic [CNT_W-1:0] op_count,
   input  logic             clear_stats
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Entry layout: {result[63:0], invalid, op, class[4:0]}
   state_t             state_q, state_d;
   logic [70:0]        main_q, main_d;
   logic [70:0]        skid_q, skid_d;
   logic               in_ready_q;
   logic [3:0]         flags_q, flags_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [70:0]        in_ent;
   logic               accept;
   logic               retire;

   function automatic logic [4:0] classify(input logic [63:0] w);
      logic [10:0] e;
      logic        f_nz;
      e    = w[62:52];
      f_nz = |w[51:0];
      if (e == 11'h7FF)  classify = f_nz ? 5'b10000 : 5'b01000;
      else if (e == '0)  classify = f_nz ? 5'b00010 : 5'b00100;
      else               classify = 5'b00001;
   endfunction

   assign in_ent = {in_result, in_invalid, in_op, classify(in_result)};
   assign accept = in_valid & in_ready_q;
   assign retire = (state_q != EMPTY) & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_d  = in_ent;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && retire) begin
               main_d = in_ent;
            end else if (accept) begin
               skid_d  = in_ent;
               state_d = FULL;
            end else if (retire) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (retire) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // Clear happens first so a same-cycle retire still contributes.
   always_comb begin
      flags_d = clear_stats ? 4'b0000 : flags_q;
      cnt_d   = clear_stats ? '0 : cnt_q;
      if (retire) begin
         flags_d = flags_d | {main_q[6], main_q[4], main_q[3], main_q[1]};
         if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         flags_q    <= 4'b0000;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= (state_d != FULL);
         flags_q    <= flags_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = (state_q != EMPTY);
   assign out_result   = main_q[70:7];
   assign out_invalid  = main_q[6];
   assign out_op       = main_q[5];
   assign out_class    = main_q[4:0];
   assign sticky_flags = flags_q;
   assign op_count     = cnt_q;

endmodule

`default_nettype wire

// File: doc/fpu_result_stage.md
Name: fpu_result_stage

Overview:
- Registered result/writeback stage directly downstream of the combinational double-precision add/sub unit.
- Accepts each 64-bit result and its invalid flag through a valid/ready handshake, and classifies the IEEE-754 encoding.
- Buffers results in a 2-entry skid buffer so the upstream unit sees a fully registered in_ready.
- Keeps sticky exception flags and a retired-operation counter for the host.

Parameters:
- CNT_W, 16, width of the retired-operation counter (saturating).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered, derived only from state.
- in_result  input  64  result word from add/sub unit.
- in_invalid  input  1  invalid-operation flag from add/sub unit.
- in_op  input  1  operation tag (0 add, 1 sub), carried through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry.
- out_result  output  64  head result word.
- out_invalid  output  1  head invalid flag.
- out_op  output  1  head operation tag.
- out_class  output  5  one-hot class of head: [4] nan, [3] inf, [2] zero, [1] denormal, [0] normal.
- sticky_flags  output  4  [3] invalid, [2] nan, [1] inf, [0] denormal; set on retirement.
- op_count  output  CNT_W  number of retired results, saturating.
- clear_stats  input  1  clears sticky_flags and op_count.

Behaviour:
- Reset: out_valid=0, in_ready=1, sticky_flags=0, op_count=0, both buffer entries empty. out_result, out_invalid, out_op and out_class are 0.
- Accept occurs when in_valid & in_ready. Retire occurs when out_valid & out_ready.
- Latency: an accepted entry appears on out_valid on the next cycle. Throughput is one per cycle while out_ready=1. Order is strictly FIFO.
- Storage is a main (output) register plus a skid register.
- States: EMPTY (main empty), ONE (main full, skid empty), FULL (both full).
  - EMPTY: accept -> ONE.
  - ONE: accept & retire -> ONE (main loads new entry). Accept only -> FULL (new entry goes to skid). Retire only -> EMPTY.
  - FULL: in_ready=0. Retire -> ONE, skid moves into main.
- in_ready = 1 in EMPTY and ONE, 0 in FULL. It is registered with no combinational path from out_ready.
- in_valid while in_ready=0 is ignored. Upstream must hold its data.
- Classification is computed on the input side and stored with the entry. Let e = bits[62:52] and f = bits[51:0]:
  - e=0x7FF, f!=0 -> nan.
  - e=0x7FF, f=0 -> inf.
  - e=0, f=0 -> zero.
  - e=0, f!=0 -> denormal.
  - otherwise normal.
  - Exactly one bit of out_class is set whenever out_valid=1.
- Sticky flags: on retire, sticky_flags |= {out_invalid, class[4], class[3], class[1]}.
- Counter: on retire, op_count increments unless it equals 2^CNT_W-1, where it holds.
- clear_stats with a retire in the same cycle: stats are cleared, then the retiring entry's contribution is applied, so flags become that entry's bits and op_count becomes 1.
- clear_stats does not affect buffered data or the handshake.
- rst mid-operation drops all buffered entries on the next edge. There is no partial output.

Test Plan:
- Basic path: after reset, send in_result=0x3FF0000000000000, in_op=0, out_ready=1. Next cycle out_valid=1, out_result matches, out_class=00001. One cycle later op_count=1 and sticky_flags=0.
- Backpressure: hold out_ready=0 and present 3 consecutive words A, B, C. A and B are accepted, in_ready drops to 0 after B, and C is held. Raise out_ready: A, B, C emerge in order with no loss or duplication, and op_count=3.
- Classes and flags: retire 0x7FF8000000000000, 0xFFF0000000000000, 0x8000000000000000 and 0x0000000000000001, with in_invalid=1 on the first only. out_class reads 10000, 01000, 00100, 00010 respectively. sticky_flags=1111 after the last retire.
- Clear collision: with sticky_flags=1111 and op_count=5, assert clear_stats in the same cycle as retiring a normal word. Result is sticky_flags=0000 and op_count=1.
- Saturation: with CNT_W=4, retire 20 results. op_count stops at 15.
- Reset mid-flight: in FULL state, assert rst for one cycle. Next cycle out_valid=0, in_ready=1, op_count=0, sticky_flags=0, and buffered entries never appear at the output.
